// File: rtl/uart_rx_word_packer.sv
// Packs four received UART bytes (little-endian) into a word and queues it in a show-ahead FIFO.
// Optional partial-word timeout, enabled by defining RX_TIMEOUT_EN.
module uart_rx_word_packer #(
    parameter int unsigned NB_DATA       = 8,
    parameter int unsigned NB_WORD       = 32,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned TIMEOUT_TICKS = 320
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_rx_done_tick,
    input  logic [NB_DATA-1:0]            i_data,
    input  logic                          i_s_tick,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [NB_WORD-1:0]            o_word,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_overflow,
    output logic                          o_timeout
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {StEmpty, StPartial} state_e;

    state_e               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [NB_WORD-1:0]   asm_q, asm_d;
    logic [NB_WORD-1:0]   push_word;
    logic                 push_req, push, pop, full;
    logic                 timeout_fire;
    logic                 timeout_q;
    logic                 overflow_q;

    logic [NB_WORD-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;

    // Top byte comes straight from i_data so the word is pushed on the 4th strobe itself.
    assign push_word = {i_data, asm_q[3*NB_DATA-1:0]};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        push_req = 1'b0;
        if (i_rx_done_tick) begin
            for (int k = 0; k < 4; k++) begin
                if (idx_q == 2'(k)) asm_d[k*NB_DATA +: NB_DATA] = i_data;
            end
            if (idx_q == 2'd3) begin
                push_req = 1'b1;
                idx_d    = 2'd0;
                asm_d    = '0;
                state_d  = StEmpty;
            end else begin
                idx_d   = idx_q + 2'd1;
                state_d = StPartial;
            end
        end else if (timeout_fire) begin
            idx_d   = 2'd0;
            asm_d   = '0;
            state_d = StEmpty;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StEmpty;
            idx_q   <= 2'd0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

    logic [TW-1:0] tcnt_q, tcnt_d;

    // A byte strobe always wins over an expiring count.
    always_comb begin
        tcnt_d       = tcnt_q;
        timeout_fire = 1'b0;
        if (state_q != StPartial || i_rx_done_tick) begin
            tcnt_d = '0;
        end else if (i_s_tick) begin
            if (tcnt_q == TW'(TIMEOUT_TICKS - 1)) begin
                timeout_fire = 1'b1;
                tcnt_d       = '0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) tcnt_q <= '0;
        else         tcnt_q <= tcnt_d;
    end
`else
    logic unused_s_tick;
    assign unused_s_tick = i_s_tick;
    assign timeout_fire  = 1'b0;
`endif

    // Pop is evaluated first so a full FIFO can still accept a push in the same cycle.
    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = (count_q != '0) && i_ready;
    assign push = push_req && (!full || pop);

    always_ff @(posedge i_clock) begin
        if (push) mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_req && !push) overflow_q <= 1'b1;
            timeout_q <= timeout_fire;
        end
    end

    assign o_valid    = (count_q != '0);
    assign o_word     = o_valid ? mem[rd_ptr_q] : '0;
    assign o_count    = count_q;
    assign o_full     = full;
    assign o_overflow = overflow_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer; timeout cases follow RX_TIMEOUT_EN.
module tb_uart_rx_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_done;
    logic [7:0]  data;
    logic        s_tick;
    logic        ready;
    logic        valid;
    logic [31:0] word;
    logic [2:0]  count;
    logic        full;
    logic        overflow;
    logic        timeout;

    int checks         = 0;
    int failures       = 0;
    int timeout_pulses = 0;

    uart_rx_word_packer #(
        .NB_DATA      (8),
        .NB_WORD      (32),
        .FIFO_DEPTH   (4),
        .TIMEOUT_TICKS(320)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_rx_done_tick(rx_done),
        .i_data        (data),
        .i_s_tick      (s_tick),
        .i_ready       (ready),
        .o_valid       (valid),
        .o_word        (word),
        .o_count       (count),
        .o_full        (full),
        .o_overflow    (overflow),
        .o_timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (timeout === 1'b1) timeout_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_done = 1'b1;
        data    = b;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(valid), 32'd1);
        check_eq(tag, word, exp);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic send_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; rx_done = 1'b0; data = 8'h00; s_tick = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_valid",    32'(valid),    32'd0);
        check_eq("rst_word",     word,          32'd0);
        check_eq("rst_count",    32'(count),    32'd0);
        check_eq("rst_full",     32'(full),     32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_timeout",  32'(timeout),  32'd0);

        // Basic little-endian packing, one cycle latency.
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
        check_eq("partial_no_valid", 32'(valid), 32'd0);
        send_byte(8'h12);
        check_eq("pack_valid", 32'(valid), 32'd1);
        check_eq("pack_word",  word,       32'h1234_5678);
        check_eq("pack_count", 32'(count), 32'd1);
        pop_expect("pack_pop", 32'h1234_5678);
        check_eq("pack_empty", 32'(valid), 32'd0);
        // Ready while empty is harmless.
        ready = 1'b1;
        repeat (2) @(negedge clk);
        ready = 1'b0;
        check_eq("idle_ready_count", 32'(count), 32'd0);

        // Fill and overflow.
        for (int i = 1; i <= 4; i++) send_word(32'(i));
        check_eq("fill_full",     32'(full),     32'd1);
        check_eq("fill_count",    32'(count),    32'd4);
        check_eq("fill_overflow", 32'(overflow), 32'd0);
        send_word(32'd5);
        check_eq("ovf_flag",  32'(overflow), 32'd1);
        check_eq("ovf_count", 32'(count),    32'd4);
        for (int i = 1; i <= 4; i++) pop_expect("ovf_pop", 32'(i));
        check_eq("ovf_empty",  32'(valid),    32'd0);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        check_eq("ovf_cleared", 32'(overflow), 32'd0);

        // Simultaneous push and pop on a full FIFO.
        for (int i = 0; i < 4; i++) send_word(32'h10 + 32'(i));
        send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hBB);
        @(negedge clk);
        check_eq("pp_head_before", word, 32'h10);
        rx_done = 1'b1; data = 8'hAA; ready = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; ready = 1'b0;
        check_eq("pp_overflow",   32'(overflow), 32'd0);
        check_eq("pp_count",      32'(count),    32'd4);
        check_eq("pp_full",       32'(full),     32'd1);
        pop_expect("pp_pop1", 32'h11);
        pop_expect("pp_pop2", 32'h12);
        pop_expect("pp_pop3", 32'h13);
        pop_expect("pp_pop4", 32'hAABB_CCDD);
        check_eq("pp_empty", 32'(valid), 32'd0);

        // Reset mid-word discards held bytes; strobe during reset is ignored.
        send_byte(8'hFF); send_byte(8'hEE);
        @(negedge clk);
        rst = 1'b1; rx_done = 1'b1; data = 8'h99;
        @(negedge clk);
        rst = 1'b0; rx_done = 1'b0;
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02);
        check_eq("mid_rst_no_valid", 32'(valid), 32'd0);
        send_byte(8'h01);
        check_eq("mid_rst_word",  word,       32'h0102_0304);
        check_eq("mid_rst_count", 32'(count), 32'd1);
        pop_expect("mid_rst_pop", 32'h0102_0304);
        check_eq("mid_rst_empty", 32'(valid), 32'd0);

`ifdef RX_TIMEOUT_EN
        do_reset();
        timeout_pulses = 0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_ticks(319);
        check_eq("to_early_pulses", 32'(timeout_pulses), 32'd0);
        send_ticks(1);
        repeat (3) @(negedge clk);
        check_eq("to_pulses", 32'(timeout_pulses), 32'd1);
        check_eq("to_fifo",   32'(count),          32'd0);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check_eq("to_word",  word,       32'hDEAD_BEEF);
        check_eq("to_count", 32'(count), 32'd1);
`else
        do_reset();
        timeout_pulses = 0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_ticks(1000);
        send_byte(8'h44);
        check_eq("nto_pulses", 32'(timeout_pulses), 32'd0);
        check_eq("nto_count",  32'(count),          32'd1);
        check_eq("nto_word",   word,                32'h4433_2211);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
